// File: rtl/vga_video_ula_pkg.sv
// Shared definitions for the video ULA: control-register layout, pixel-rate
// encoding and character lengths.
package vga_video_ula_pkg;

    localparam int CTRL_CURS_HI = 7;
    localparam int CTRL_CURS_MD = 6;
    localparam int CTRL_CURS_LO = 5;
    localparam int CTRL_FAST    = 4;
    localparam int CTRL_PPC_HI  = 3;
    localparam int CTRL_PPC_LO  = 2;
    localparam int CTRL_RSVD    = 1;
    localparam int CTRL_FLASH   = 0;

    typedef enum logic [1:0] {
        PPC_2  = 2'b00,
        PPC_4  = 2'b01,
        PPC_8  = 2'b10,
        PPC_16 = 2'b11
    } ppc_e;

    localparam int CHAR_LEN_SLOW = 16;
    localparam int CHAR_LEN_FAST = 8;

    typedef struct packed {
        logic       act;
        logic [1:0] seg;
    } curs_t;

    // log2 of the pixel period. Fast clock at 16 pixels per character would
    // need half-cycle pixels, so it clamps to one pixel per cycle.
    function automatic logic [1:0] pix_log2(input logic fast, input ppc_e ppc);
        int l;
        l = (fast ? $clog2(CHAR_LEN_FAST) : $clog2(CHAR_LEN_SLOW)) - (int'(ppc) + 1);
        return (l < 0) ? 2'd0 : 2'(l);
    endfunction

endpackage

// File: rtl/vga_video_ula.sv
// Video ULA: character-rate divider, display-byte shifter, 16-entry palette
// with flash, cursor overlay and registered 3-bit RGB output.
module vga_video_ula
    import vga_video_ula_pkg::*;
(
    input  logic       PIXELCLK,
    input  logic       nRESET,
    input  logic       PROC_en,
    input  logic       nCS,
    input  logic       RnW,
    input  logic       A0,
    input  logic [7:0] DATABUS,
    input  logic [7:0] VRAM_DATA,
    input  logic       DISEN,
    input  logic       CURSOR,
    output logic       CRTC_en,
    output logic [2:0] RGB
);

    logic [3:0] cnt;
    logic [7:0] ctrl;
    logic [3:0] palette [16];
    logic [7:0] sh;
    logic       disen_q;
    curs_t      curs;

    logic       fast;
    ppc_e       ppc;
    logic [1:0] lgp;
    logic [3:0] pmask;
    logic       pix_tick;
    logic       wr_en;
    logic [3:0] idx;
    logic [3:0] p;
    logic [2:0] colour;
    logic       cursor_on;
    logic [2:0] rgb_next;
    logic       ctrl_unused;

    assign ctrl_unused = ctrl[CTRL_RSVD];

    assign fast  = ctrl[CTRL_FAST];
    assign ppc   = ppc_e'(ctrl[CTRL_PPC_HI:CTRL_PPC_LO]);
    assign lgp   = pix_log2(fast, ppc);
    assign pmask = 4'((5'd1 << lgp) - 5'd1);

    // Characters always end with the low counter bits all ones, so pixel
    // boundaries stay aligned to character boundaries without a separate phase.
    assign pix_tick = &(cnt | ~pmask);
    assign CRTC_en  = fast ? (&cnt[2:0]) : (&cnt);

    assign wr_en = PROC_en & ~nCS & ~RnW;

    assign idx = {sh[7], sh[5], sh[3], sh[1]};
    assign p   = palette[idx];

    always_comb begin
        colour = ~p[2:0];
        if (ctrl[CTRL_FLASH] && p[3])
            colour = ~colour;
    end

    always_comb begin
        cursor_on = 1'b0;
        if (curs.act) begin
            case (curs.seg)
                2'd0:    cursor_on = ctrl[CTRL_CURS_HI];
                2'd1:    cursor_on = ctrl[CTRL_CURS_MD];
                default: cursor_on = ctrl[CTRL_CURS_LO];
            endcase
        end
    end

    // Cursor inverts even outside the display window, as the 6845 does.
    assign rgb_next = (disen_q ? colour : 3'b000) ^ {3{cursor_on}};

    always_ff @(posedge PIXELCLK) begin
        if (!nRESET) begin
            cnt     <= '0;
            ctrl    <= '0;
            sh      <= 8'hFF;
            disen_q <= 1'b0;
            curs    <= '0;
            RGB     <= '0;
            for (int i = 0; i < 16; i++)
                palette[i] <= '0;
        end else begin
            cnt <= cnt + 4'd1;
            RGB <= rgb_next;

            if (wr_en) begin
                if (A0)
                    palette[DATABUS[7:4]] <= DATABUS[3:0];
                else
                    ctrl <= DATABUS;
            end

            if (CRTC_en) begin
                sh      <= VRAM_DATA;
                disen_q <= DISEN;
                if (CURSOR)
                    curs <= '{act: 1'b1, seg: 2'd0};
                else if (curs.act) begin
                    if (curs.seg == 2'd3)
                        curs.act <= 1'b0;
                    else
                        curs.seg <= curs.seg + 2'd1;
                end
            end else if (pix_tick) begin
                sh <= {sh[6:0], 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_vga_video_ula.sv
// Self-checking bench for vga_video_ula: directed scenarios plus randomized
// traffic, all checked every cycle against a character/pixel-level model.
module tb_vga_video_ula;

    logic       PIXELCLK = 1'b0;
    logic       nRESET   = 1'b0;
    logic       PROC_en  = 1'b0;
    logic       nCS      = 1'b1;
    logic       RnW      = 1'b1;
    logic       A0       = 1'b0;
    logic [7:0] DATABUS  = '0;
    logic [7:0] VRAM_DATA = '0;
    logic       DISEN    = 1'b0;
    logic       CURSOR   = 1'b0;
    logic       CRTC_en;
    logic [2:0] RGB;

    vga_video_ula dut (
        .PIXELCLK (PIXELCLK),
        .nRESET   (nRESET),
        .PROC_en  (PROC_en),
        .nCS      (nCS),
        .RnW      (RnW),
        .A0       (A0),
        .DATABUS  (DATABUS),
        .VRAM_DATA(VRAM_DATA),
        .DISEN    (DISEN),
        .CURSOR   (CURSOR),
        .CRTC_en  (CRTC_en),
        .RGB      (RGB)
    );

    always #5 PIXELCLK = ~PIXELCLK;

    int         n_chk = 0;
    int         n_err = 0;
    string      phase = "reset";

    // Reference state: register image, the character currently on screen
    // and how many characters ago the cursor was flagged.
    int         cyc;
    logic [7:0] m_ctrl;
    logic [3:0] m_pal [16];
    bit         loaded;
    int         ld_T;
    logic [7:0] ld_byte;
    bit         ld_den;
    int         age;
    logic [2:0] exp_rgb;
    bit         pend_wr;
    bit         pend_a0;
    logic [7:0] pend_d;
    bit         cur_arm = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s cyc=%0d: got %0h expected %0h", phase, tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        m_ctrl  = '0;
        for (int i = 0; i < 16; i++) m_pal[i] = '0;
        loaded  = 1'b0;
        ld_T    = 0;
        ld_byte = 8'hFF;
        ld_den  = 1'b0;
        age     = 4;
        exp_rgb = '0;
        pend_wr = 1'b0;
        pend_a0 = 1'b0;
        pend_d  = '0;
    endtask

    // Pixel k of a character is the byte shifted left k times with ones fed in.
    function automatic logic [2:0] model_rgb();
        int         clen, ppc, per, k, v;
        logic [3:0] ix, pe;
        logic [2:0] col;
        bit         con;
        clen = m_ctrl[4] ? 8 : 16;
        ppc  = 2 << m_ctrl[3:2];
        per  = clen / ppc;
        if (per < 1) per = 1;
        if (!loaded) v = 255;
        else begin
            k = (cyc - ld_T - 1) / per;
            v = (k >= 8) ? 255 : (((int'(ld_byte) << k) | ((1 << k) - 1)) & 255);
        end
        ix  = {v[7], v[5], v[3], v[1]};
        pe  = m_pal[ix];
        col = ~pe[2:0];
        if (m_ctrl[0] && pe[3]) col = ~col;
        if (!ld_den) col = 3'b000;
        con = (age == 0) ? m_ctrl[7] : (age == 1) ? m_ctrl[6] : (age <= 3) ? m_ctrl[5] : 1'b0;
        if (con) col = col ^ 3'b111;
        return col;
    endfunction

    // One clock: check this cycle, predict next RGB, drive inputs for the
    // coming edge. VRAM/DISEN/CURSOR are random except on terminal cycles.
    task automatic step(input bit rst, input bit wr, input bit a0, input logic [7:0] d,
                        input logic [7:0] vram, input bit den);
        bit term, c_in;
        int r;
        @(negedge PIXELCLK);
        if (pend_wr) begin
            if (pend_a0) m_pal[pend_d[7:4]] = pend_d[3:0];
            else         m_ctrl = pend_d;
            pend_wr = 1'b0;
        end
        term = m_ctrl[4] ? (cyc % 8 == 7) : (cyc % 16 == 15);
        chk("crtc_en", 8'(CRTC_en), 8'(term));
        chk("rgb", 8'(RGB), 8'(exp_rgb));
        exp_rgb = model_rgb();

        c_in = term ? cur_arm : 1'($urandom);
        r = $urandom_range(2);
        nRESET    = !rst;
        PROC_en   = wr || (r != 0);
        nCS       = !wr && (r == 1);
        RnW       = !wr && (r == 2);
        A0        = wr ? a0 : 1'($urandom);
        DATABUS   = wr ? d : 8'($urandom);
        VRAM_DATA = term ? vram : 8'($urandom);
        DISEN     = term ? den : 1'($urandom);
        CURSOR    = c_in;

        if (rst) model_reset();
        else begin
            if (wr) begin
                pend_wr = 1'b1;
                pend_a0 = a0;
                pend_d  = d;
            end
            if (term) begin
                loaded  = 1'b1;
                ld_T    = cyc;
                ld_byte = vram;
                ld_den  = den;
                age     = c_in ? 0 : ((age < 4) ? age + 1 : 4);
                cur_arm = 1'b0;
            end
            cyc++;
        end
    endtask

    task automatic do_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wr_reg(input bit a0, input logic [7:0] d);
        step(1'b0, 1'b1, a0, d, 8'($urandom), 1'b1);
    endtask

    task automatic run(input int n, input int vram, input bit den);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 8'h00, (vram < 0) ? 8'($urandom) : vram[7:0], den);
    endtask

    initial begin
        int         r;
        logic [2:0] mode;
        model_reset();

        phase = "divider";
        do_reset();
        wr_reg(1'b0, 8'h00);
        run(40, 8'hFF, 1'b0);
        wr_reg(1'b0, 8'h10);
        run(40, 8'hFF, 1'b0);

        phase = "1bpp";
        do_reset();
        wr_reg(1'b0, 8'h18);
        for (int i = 0; i < 16; i++) wr_reg(1'b1, {4'(i), (i < 8) ? 4'h7 : 4'h0});
        run(40, 8'hAA, 1'b1);

        phase = "4bpp";
        do_reset();
        wr_reg(1'b0, 8'h04);
        wr_reg(1'b1, 8'hC6);
        wr_reg(1'b1, 8'h07);
        run(80, 8'hA0, 1'b1);

        phase = "flash";
        do_reset();
        wr_reg(1'b0, 8'h04);
        for (int i = 0; i < 16; i++) wr_reg(1'b1, {4'(i), 4'hE});
        run(40, -1, 1'b1);
        wr_reg(1'b0, 8'h05);
        run(40, -1, 1'b1);

        phase = "cursor";
        do_reset();
        wr_reg(1'b0, 8'hA8);
        for (int i = 0; i < 16; i++) wr_reg(1'b1, {4'(i), 4'($urandom)});
        cur_arm = 1'b1;
        run(16 * 7, -1, 1'b1);

        phase = "blank";
        run(48, -1, 1'b0);

        phase = "midreset";
        run(21, -1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        run(48, -1, 1'b1);

        phase = "random";
        for (int rnd = 0; rnd < 6; rnd++) begin
            mode = 3'($urandom);
            do_reset();
            wr_reg(1'b0, (8'($urandom) & 8'hE3) | {3'b000, mode, 2'b00});
            for (int i = 0; i < 16; i++) wr_reg(1'b1, {4'(i), 4'($urandom)});
            for (int i = 0; i < 600; i++) begin
                r = $urandom_range(99);
                if ($urandom_range(99) < 3) cur_arm = 1'b1;
                if (r < 8)
                    step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), ($urandom_range(3) != 0));
                else if (r < 11)
                    step(1'b0, 1'b1, 1'b0, (8'($urandom) & 8'hE3) | {3'b000, mode, 2'b00},
                         8'($urandom), ($urandom_range(3) != 0));
                else
                    step(1'b0, 1'b0, 1'b0, 8'h00, 8'($urandom), ($urandom_range(3) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
